// File: rtl/alu_sequencer.sv
// Sequencer stepping the nibble-serial ALU through one 8-bit operation:
// load OP1, load OP2 + low nibble, high nibble, then present result and flags.
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic       cf_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       cf_out,
  output logic       hf_out,
  output logic       pf_out,
  output logic       zf_out,
  output logic       sf_out,
  output logic       vf_out,
  output logic [7:0] db_w,
  output logic       db_drive,
  input  logic [7:0] db,
  output logic       alu_op1_oe,
  output logic       alu_op2_oe,
  output logic       alu_res_oe,
  output logic       alu_shift_oe,
  output logic       alu_bs_oe,
  output logic       alu_shift_in,
  output logic       alu_shift_left,
  output logic       alu_shift_right,
  output logic       alu_op1_sel_bus,
  output logic       alu_op2_sel_bus,
  output logic       alu_sel_op2_neg,
  output logic       alu_sel_op2_high,
  output logic       alu_op_low,
  output logic       alu_core_cf_in,
  output logic       alu_core_R,
  output logic       alu_core_S,
  output logic       alu_core_V,
  output logic       alu_parity_in,
  input  logic       alu_core_cf_out,
  input  logic       alu_parity_out,
  input  logic       alu_zero,
  input  logic       alu_sf_out,
  input  logic       alu_vf_out
);

  localparam int NONE_OPS = 8;
  localparam int OP_W     = $clog2(NONE_OPS);
  localparam int DATA_W   = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_ADC = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB = 3'd2;
  localparam logic [OP_W-1:0] OP_SBC = 3'd3;
  localparam logic [OP_W-1:0] OP_AND = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;
  localparam logic [OP_W-1:0] OP_OR  = 3'd6;
  localparam logic [OP_W-1:0] OP_CP  = 3'd7;

  typedef enum logic [2:0] {IDLE, LOAD1, LOW, HIGH, DONE} state_t;

  state_t            state, state_nx;
  logic [OP_W-1:0]   op_r;
  logic [DATA_W-1:0] a_r, b_r;
  logic              cfin_r;
  logic              hf_int, p_low, z_low;

  function automatic logic is_sub(input logic [OP_W-1:0] o);
    return (o == OP_SUB) || (o == OP_SBC) || (o == OP_CP);
  endfunction

  function automatic logic is_logic(input logic [OP_W-1:0] o);
    return (o == OP_AND) || (o == OP_XOR) || (o == OP_OR);
  endfunction

  function automatic logic [2:0] rsv_code(input logic [OP_W-1:0] o);
    case (o)
      OP_AND:  return 3'b010;
      OP_OR:   return 3'b100;
      OP_XOR:  return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  // Subtraction is a + ~b + 1, so the borrow-in enters inverted.
  function automatic logic low_carry(input logic [OP_W-1:0] o, input logic c);
    case (o)
      OP_ADC:        return c;
      OP_SBC:        return !c;
      OP_SUB, OP_CP: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic final_cf(input logic [OP_W-1:0] o, input logic c);
    if (is_logic(o)) return 1'b0;
    return is_sub(o) ? !c : c;
  endfunction

  function automatic logic final_hf(input logic [OP_W-1:0] o, input logic h);
    if (o == OP_AND) return 1'b1;
    if (is_logic(o)) return 1'b0;
    return is_sub(o) ? !h : h;
  endfunction

  assign alu_op1_oe      = 1'b0;
  assign alu_op2_oe      = 1'b0;
  assign alu_bs_oe       = 1'b0;
  assign alu_shift_in    = 1'b0;
  assign alu_shift_left  = 1'b0;
  assign alu_shift_right = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    busy             = (state != IDLE);
    done             = 1'b0;
    db_drive         = 1'b0;
    db_w             = '0;
    alu_res_oe       = 1'b0;
    alu_shift_oe     = 1'b0;
    alu_op1_sel_bus  = 1'b0;
    alu_op2_sel_bus  = 1'b0;
    alu_sel_op2_neg  = 1'b0;
    alu_sel_op2_high = 1'b0;
    alu_op_low       = 1'b0;
    alu_core_cf_in   = 1'b0;
    alu_parity_in    = 1'b0;
    {alu_core_R, alu_core_S, alu_core_V} = 3'b000;
    case (state)
      IDLE: if (start) state_nx = LOAD1;
      LOAD1: begin
        db_drive        = 1'b1;
        db_w            = a_r;
        alu_shift_oe    = 1'b1;
        alu_op1_sel_bus = 1'b1;
        state_nx        = LOW;
      end
      LOW: begin
        db_drive        = 1'b1;
        db_w            = b_r;
        alu_shift_oe    = 1'b1;
        alu_op2_sel_bus = 1'b1;
        alu_op_low      = 1'b1;
        alu_sel_op2_neg = is_sub(op_r);
        alu_core_cf_in  = low_carry(op_r, cfin_r);
        {alu_core_R, alu_core_S, alu_core_V} = rsv_code(op_r);
        state_nx        = HIGH;
      end
      HIGH: begin
        alu_res_oe       = 1'b1;
        alu_sel_op2_high = 1'b1;
        alu_sel_op2_neg  = is_sub(op_r);
        alu_core_cf_in   = hf_int;
        alu_parity_in    = p_low;
        {alu_core_R, alu_core_S, alu_core_V} = rsv_code(op_r);
        state_nx         = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Acceptance boundary: operands frozen for the whole operation.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op_r   <= op;
      a_r    <= op_a;
      b_r    <= op_b;
      cfin_r <= cf_in;
    end
    if (state == LOW) begin
      hf_int <= alu_core_cf_out;
      p_low  <= alu_parity_out;
      z_low  <= alu_zero;
    end
  end

  // High-nibble boundary: result and finalised flags become visible in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      cf_out <= 1'b0;
      hf_out <= 1'b0;
      pf_out <= 1'b0;
      zf_out <= 1'b0;
      sf_out <= 1'b0;
      vf_out <= 1'b0;
    end else if (state == HIGH) begin
      result <= db;
      cf_out <= final_cf(op_r, alu_core_cf_out);
      hf_out <= final_hf(op_r, hf_int);
      pf_out <= is_logic(op_r) ? alu_parity_out : alu_vf_out;
      zf_out <= z_low & alu_zero;
      sf_out <= alu_sf_out;
      vf_out <= alu_vf_out;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural nibble-serial ALU attached.
module tb_alu_sequencer;

  logic       clk, reset, start, cf_in;
  logic [2:0] op;
  logic [7:0] op_a, op_b, db_w, db, result;
  logic       busy, done, cf_out, hf_out, pf_out, zf_out, sf_out, vf_out, db_drive;
  logic       alu_op1_oe, alu_op2_oe, alu_res_oe, alu_shift_oe, alu_bs_oe;
  logic       alu_shift_in, alu_shift_left, alu_shift_right;
  logic       alu_op1_sel_bus, alu_op2_sel_bus, alu_sel_op2_neg, alu_sel_op2_high, alu_op_low;
  logic       alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V, alu_parity_in;
  logic       alu_core_cf_out, alu_parity_out, alu_zero, alu_sf_out, alu_vf_out;

  int checks = 0;
  int failures = 0;
  int inv_err = 0;
  int done_cnt = 0;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .cf_in(cf_in), .busy(busy), .done(done), .result(result),
    .cf_out(cf_out), .hf_out(hf_out), .pf_out(pf_out), .zf_out(zf_out),
    .sf_out(sf_out), .vf_out(vf_out), .db_w(db_w), .db_drive(db_drive), .db(db),
    .alu_op1_oe(alu_op1_oe), .alu_op2_oe(alu_op2_oe), .alu_res_oe(alu_res_oe),
    .alu_shift_oe(alu_shift_oe), .alu_bs_oe(alu_bs_oe),
    .alu_shift_in(alu_shift_in), .alu_shift_left(alu_shift_left),
    .alu_shift_right(alu_shift_right),
    .alu_op1_sel_bus(alu_op1_sel_bus), .alu_op2_sel_bus(alu_op2_sel_bus),
    .alu_sel_op2_neg(alu_sel_op2_neg), .alu_sel_op2_high(alu_sel_op2_high),
    .alu_op_low(alu_op_low), .alu_core_cf_in(alu_core_cf_in),
    .alu_core_R(alu_core_R), .alu_core_S(alu_core_S), .alu_core_V(alu_core_V),
    .alu_parity_in(alu_parity_in), .alu_core_cf_out(alu_core_cf_out),
    .alu_parity_out(alu_parity_out), .alu_zero(alu_zero),
    .alu_sf_out(alu_sf_out), .alu_vf_out(alu_vf_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: operand latches, 4-bit core, low-nibble result latch.
  logic [7:0] op1_q, op2_q, op2_v;
  logic [3:0] lo_q, na, nb, nres, s3;
  logic [4:0] sum;
  logic       arith;

  always_comb begin
    op2_v = alu_op2_sel_bus ? db_w : op2_q;
    na    = alu_op_low ? op1_q[3:0] : op1_q[7:4];
    nb    = alu_sel_op2_high ? op2_v[7:4] : op2_v[3:0];
    if (alu_sel_op2_neg) nb = ~nb;
    sum   = {1'b0, na} + {1'b0, nb} + {4'b0, alu_core_cf_in};
    s3    = {1'b0, na[2:0]} + {1'b0, nb[2:0]} + {3'b0, alu_core_cf_in};
    arith = ({alu_core_R, alu_core_S, alu_core_V} == 3'b000);
    case ({alu_core_R, alu_core_S, alu_core_V})
      3'b010:  nres = na & nb;
      3'b100:  nres = na | nb;
      3'b110:  nres = na ^ nb;
      default: nres = sum[3:0];
    endcase
    alu_core_cf_out = arith ? sum[4] : 1'b0;
    alu_vf_out      = arith ? (s3[3] ^ sum[4]) : 1'b0;
    alu_zero        = (nres == 4'h0);
    alu_sf_out      = nres[3];
    alu_parity_out  = alu_parity_in ^ (^nres) ^ alu_op_low;
  end

  always_ff @(posedge clk) begin
    if (alu_op1_sel_bus) op1_q <= db_w;
    if (alu_op2_sel_bus) op2_q <= db_w;
    if (alu_op_low)      lo_q  <= nres;
  end

  assign db = db_drive ? db_w : (alu_res_oe ? {nres, lo_q} : 8'hFF);

  always @(posedge clk) begin
    if (!$onehot0({alu_op1_oe, alu_op2_oe, alu_res_oe, alu_shift_oe, alu_bs_oe}) ||
        alu_bs_oe || alu_shift_in || alu_shift_left || alu_shift_right ||
        (db_drive && alu_res_oe))
      inv_err <= inv_err + 1;
    done_cnt <= done_cnt + int'(done);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input bit poke, output int lat);
    @(negedge clk);
    op = o; op_a = a; op_b = b; cf_in = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (poke && k == 2) begin
        op_a = 8'hFF; op = 3'd5; cf_in = 1'b1;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  function automatic logic [5:0] flags();
    return {cf_out, hf_out, zf_out, sf_out, vf_out, pf_out};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int lat, d0, n_done, first_k, last_k;
    clk = 0; reset = 1; start = 0; op = 0; op_a = 0; op_b = 0; cf_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_db_drive", db_drive, 0);
    reset = 0;

    // flag order: cf hf zf sf vf pf
    run_op(3'd0, 8'h8C, 8'h6D, 1'b0, 0, lat);
    chk("add_lat", lat, 4);
    chk("add_busy", busy, 1);
    chk("add_res", result, 8'hF9);
    chk("add_flags", flags(), 6'b010100);

    run_op(3'd1, 8'hFF, 8'h00, 1'b1, 0, lat);
    chk("adc_res", result, 8'h00);
    chk("adc_flags", flags(), 6'b111000);

    run_op(3'd2, 8'h10, 8'h01, 1'b0, 0, lat);
    chk("sub_res", result, 8'h0F);
    chk("sub_flags", flags(), 6'b010000);

    run_op(3'd7, 8'h05, 8'h07, 1'b0, 0, lat);
    chk("cp_res", result, 8'hFE);
    chk("cp_flags", flags(), 6'b110100);

    run_op(3'd4, 8'hF0, 8'h0F, 1'b0, 0, lat);
    chk("and_res", result, 8'h00);
    chk("and_flags", flags(), 6'b011001);

    run_op(3'd5, 8'h55, 8'h0F, 1'b0, 0, lat);
    chk("xor_res", result, 8'h5A);
    chk("xor_flags", flags(), 6'b000001);

    // inputs changed mid-operation must not disturb the registered operands
    run_op(3'd0, 8'h12, 8'h34, 1'b0, 1, lat);
    chk("poke_lat", lat, 4);
    chk("poke_res", result, 8'h46);
    chk("poke_flags", flags(), 6'b000000);

    // start held high: acceptance only from IDLE, done every 5 cycles
    @(negedge clk);
    op = 3'd0; op_a = 8'h01; op_b = 8'h02; cf_in = 1'b0; start = 1'b1;
    n_done = 0; first_k = 0; last_k = 0;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_k == 0) first_k = k;
        last_k = k;
      end
    end
    start = 1'b0;
    chk("held_count", n_done, 4);
    chk("held_first", first_k, 4);
    chk("held_last", last_k, 19);
    chk("held_res", result, 8'h03);
    chk("held_idle", busy, 0);

    // reset during HIGH aborts with no done
    @(negedge clk);
    op = 3'd0; op_a = 8'h8C; op_b = 8'h6D; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_res_oe", alu_res_oe, 1);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", flags(), 0);
    chk("abort_bus", {db_drive, db_w, alu_res_oe, alu_shift_oe}, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    run_op(3'd0, 8'h01, 8'h01, 1'b0, 0, lat);
    chk("post_lat", lat, 4);
    chk("post_res", result, 8'h02);

    chk("invariants", inv_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control sequencer that drives the nibble-serial ALU block through one complete 8-bit operation: load OP1, load OP2, compute low nibble, compute high nibble, read back result and flags.
- Sits between the instruction-timing logic and the ALU, replacing hand-driven control strobes with a fixed, registered schedule.
- Provides the start/busy/done handshake, the 8-bit result and Z80 flags.

Parameters:
- NONE_OPS, 8, number of supported operations (fixed encoding below; not for override)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP
- op_a  in  8  operand 1
- op_b  in  8  operand 2
- cf_in  in  1  carry flag for ADC/SBC
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse, result and flags valid
- result  out  8  registered result
- cf_out, hf_out, pf_out, zf_out, sf_out, vf_out  out  1 each  registered flags
- db_w  out  8  value driven onto ALU external bus
- db_drive  out  1  sequencer drives db (ALU alu_oe = !db_drive)
- db  in  8  ALU external bus readback
- alu_op1_oe, alu_op2_oe, alu_res_oe, alu_shift_oe, alu_bs_oe  out  1 each  internal bus writer select, one-hot or zero
- alu_shift_in, alu_shift_left, alu_shift_right  out  1 each  tied 0
- alu_op1_sel_bus, alu_op2_sel_bus, alu_sel_op2_neg, alu_sel_op2_high, alu_op_low  out  1 each  ALU latch/mux control
- alu_core_cf_in, alu_core_R, alu_core_S, alu_core_V, alu_parity_in  out  1 each  ALU core control
- alu_core_cf_out, alu_parity_out, alu_zero, alu_sf_out, alu_vf_out  in  1 each  ALU status

Behaviour:
- Reset:
  - state IDLE.
  - All outputs 0, including result, flags, busy and done.
  - db_drive=0.
  - Reset mid-operation aborts at the next edge, and no done is issued.
- FSM: IDLE -> LOAD1 -> LOW -> HIGH -> DONE -> IDLE.
  - start sampled high in IDLE at edge N gives LOAD1 in cycle N+1, LOW in N+2, HIGH in N+3, and DONE in N+4 with done=1.
  - Latency is 4 cycles, with one op per 5 cycles.
  - start outside IDLE is ignored.
  - op, op_a, op_b and cf_in are registered at acceptance; later input changes have no effect.
- busy=1 in LOAD1, LOW, HIGH and DONE.
- LOAD1 cycle: db_drive=1, db_w=op_a, alu_shift_oe=1, alu_op1_sel_bus=1.
- LOW cycle (low nibble):
  - db_drive=1, db_w=op_b, alu_shift_oe=1, alu_op2_sel_bus=1.
  - alu_op_low=1, alu_sel_op2_high=0, alu_parity_in=0.
  - Carry-in: alu_core_cf_in=0 for ADD/logic, cf_in for ADC, 1 for SUB/CP, !cf_in for SBC.
  - At the closing edge: hf_int<=alu_core_cf_out, p_low<=alu_parity_out, z_low<=alu_zero.
- HIGH cycle (high nibble):
  - db_drive=0, alu_res_oe=1, alu_sel_op2_high=1, alu_op_low=0.
  - alu_core_cf_in=hf_int, alu_parity_in=p_low.
  - At the closing edge: result<=db; cf_int<=alu_core_cf_out; zf_out<=z_low & alu_zero; sf_out<=alu_sf_out; vf_out<=alu_vf_out; par<=alu_parity_out.
- alu_sel_op2_neg=1 in LOW and HIGH for SUB, SBC and CP; otherwise 0.
- R/S/V encoding:
  - ADD/ADC/SUB/SBC/CP: 000.
  - AND: 010.
  - OR: 100.
  - XOR: 110.
  - Held constant in LOW and HIGH; 0 in other states.
- Flag finalisation, visible in the DONE cycle:
  - cf_out: cf_int for ADD/ADC; !cf_int for SUB/SBC/CP; 0 for logic ops.
  - hf_out: hf_int for ADD/ADC; !hf_int for SUB/SBC/CP; 1 for AND; 0 for OR/XOR.
  - pf_out: vf_out for arithmetic; par (1 = even) for logic.
  - CP: result register updated (flags identical to SUB); the consumer discards it.
- Outputs hold their last value until the next completion or reset.
- Invariants, asserted by the bench:
  - At most one alu_*_oe high in any cycle.
  - alu_bs_oe and the shift controls are always 0.
  - db_drive=0 whenever alu_res_oe=1.

Test Plan:
- ADD, op_a=8C, op_b=6D -> done at N+4; result=F9, cf=0, hf=1, zf=0, sf=1, vf=0, pf=0; alu_op1_oe..alu_bs_oe never overlap.
- ADC, FF+00, cf_in=1 -> result=00, cf=1, hf=1, zf=1, sf=0, vf=0.
- SUB, 10-01 -> result=0F, cf=0, hf=1, zf=0, vf=0. Then CP 05 vs 07 -> result=FE, cf=1, sf=1, zf=0.
- AND F0&0F -> result=00, zf=1, hf=1, pf=1, cf=0. XOR 55^0F -> result=5A, pf=1, hf=0.
- start held high continuously -> an op is accepted only in IDLE, one done per 5 cycles. Changing op_a during LOW does not alter the result.
- reset asserted during HIGH -> next cycle IDLE with busy=0, done=0, all outputs 0 and no done pulse. A subsequent ADD 01+01 -> result=02.
